// File: rtl/avg_window.sv
// Sliding-window averager: DEPTH-entry circular buffer with running sum.
// Emits either the floor mean or the buffered sample closest to it.
module avg_window #(
    parameter int unsigned DW    = 16,
    parameter int unsigned DEPTH = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] din,
    input  logic          din_valid,
    output logic          din_ready,
    input  logic          mode,
    output logic          ready,
    output logic [DW-1:0] dout,
    output logic          dout_valid
);

    localparam int unsigned SW = DW + $clog2(DEPTH);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        S_FILL,
        S_WAIT,
        S_CALC,
        S_SCAN,
        S_EMIT
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [SW-1:0]   sum_q, sum_d;
    logic [DW-1:0]   avg_q, avg_d;
    logic            mode_q, mode_d;
    logic [PW-1:0]   idx_q, idx_d;
    logic [DW-1:0]   best_q, best_d;
    logic [DW-1:0]   best_dist_q, best_dist_d;
    logic            ready_q, ready_d;
    logic            din_ready_q, din_ready_d;
    logic [DW-1:0]   dout_q, dout_d;
    logic            dout_valid_q, dout_valid_d;

    logic [DW-1:0]   mem_q [DEPTH];

    logic            accept_c;
    logic            wr_en_c;
    logic [PW-1:0]   ptr_next_c;
    logic [DW-1:0]   old_c;
    logic [DW-1:0]   rd_c;
    logic [DW-1:0]   dist_c;
    logic            take_c;

    assign accept_c   = din_valid && din_ready_q;
    assign ptr_next_c = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    assign old_c      = mem_q[wr_ptr_q];
    assign rd_c       = mem_q[idx_q];
    assign dist_c     = (rd_c >= avg_q) ? (rd_c - avg_q) : (avg_q - rd_c);
    // Ties go to the sample at or below the mean.
    assign take_c     = (dist_c < best_dist_q) ||
                        ((dist_c == best_dist_q) && (rd_c <= avg_q));

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        wr_ptr_d     = wr_ptr_q;
        sum_d        = sum_q;
        avg_d        = avg_q;
        mode_d       = mode_q;
        idx_d        = idx_q;
        best_d       = best_q;
        best_dist_d  = best_dist_q;
        ready_d      = ready_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        wr_en_c      = 1'b0;

        case (state_q)
            S_FILL: begin
                if (accept_c) begin
                    wr_en_c  = 1'b1;
                    sum_d    = sum_q + SW'(din);
                    count_d  = count_q + CW'(1);
                    wr_ptr_d = ptr_next_c;
                    if (count_q == CW'(DEPTH - 1)) begin
                        ready_d = 1'b1;
                        state_d = S_CALC;
                    end
                end
            end
            S_WAIT: begin
                if (accept_c) begin
                    wr_en_c  = 1'b1;
                    sum_d    = sum_q - SW'(old_c) + SW'(din);
                    wr_ptr_d = ptr_next_c;
                    state_d  = S_CALC;
                end
            end
            S_CALC: begin
                avg_d       = DW'(sum_q / SW'(DEPTH));
                mode_d      = mode;
                idx_d       = '0;
                best_d      = '0;
                best_dist_d = '1;
                state_d     = mode ? S_EMIT : S_SCAN;
            end
            S_SCAN: begin
                if (take_c) begin
                    best_d      = rd_c;
                    best_dist_d = dist_c;
                end
                if (idx_q == PW'(DEPTH - 1)) begin
                    state_d = S_EMIT;
                end else begin
                    idx_d = idx_q + PW'(1);
                end
            end
            S_EMIT: begin
                dout_d       = mode_q ? avg_q : best_q;
                dout_valid_d = 1'b1;
                state_d      = S_WAIT;
            end
            default: state_d = S_FILL;
        endcase

        din_ready_d = (state_d == S_FILL) || (state_d == S_WAIT);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_FILL;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            sum_q        <= '0;
            avg_q        <= '0;
            mode_q       <= 1'b0;
            idx_q        <= '0;
            best_q       <= '0;
            best_dist_q  <= '0;
            ready_q      <= 1'b0;
            din_ready_q  <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            sum_q        <= sum_d;
            avg_q        <= avg_d;
            mode_q       <= mode_d;
            idx_q        <= idx_d;
            best_q       <= best_d;
            best_dist_q  <= best_dist_d;
            ready_q      <= ready_d;
            din_ready_q  <= din_ready_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    // Sample storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign din_ready  = din_ready_q;
    assign ready      = ready_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_avg_window.sv
// Directed self-checking bench for avg_window with default parameters.
module tb_avg_window;

    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 12;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] din;
    logic          din_valid;
    logic          din_ready;
    logic          mode;
    logic          ready;
    logic [DW-1:0] dout;
    logic          dout_valid;

    int tests  = 0;
    int fails  = 0;
    int cyc    = 0;
    int pulses = 0;

    avg_window #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .mode       (mode),
        .ready      (ready),
        .dout       (dout),
        .dout_valid (dout_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (dout_valid) pulses <= pulses + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present one sample and hold it until the accept edge.
    task automatic push(input logic [DW-1:0] v, input logic md);
        int n = 0;
        din       = v;
        mode      = md;
        din_valid = 1'b1;
        while (!din_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!din_ready) check("push_timeout", 32'(din_ready), 32'd1);
        @(posedge clk); #1;
        din_valid = 1'b0;
    endtask

    // Called #1 after the accept edge; lat counts edges from that edge.
    task automatic wait_result(input string tag, input int lat, input logic [DW-1:0] exp);
        int n    = 0;
        int busy = 0;
        while (!dout_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (!dout_valid && din_ready) busy++;
        end
        check({tag, "_lat"}, 32'(n), 32'(lat));
        check({tag, "_dout"}, 32'(dout), 32'(exp));
        check({tag, "_rdy_low"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
        check({tag, "_pulse"}, 32'(dout_valid), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p0;
        int prev;
        int gaps_bad;

        reset     = 1'b0;
        din       = '0;
        din_valid = 1'b0;
        mode      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_dout_valid", 32'(dout_valid), 32'd0);
        check("rst_din_ready", 32'(din_ready), 32'd0);
        reset = 1'b1;

        // Fill with 1..12: sum 78, avg 6, closest sample 6.
        p0 = pulses;
        for (int i = 1; i <= 12; i++) begin
            push(DW'(i), 1'b0);
            if (i == 11) check("fill_ready_before", 32'(ready), 32'd0);
        end
        check("fill_ready", 32'(ready), 32'd1);
        check("fill_no_dv", 32'(pulses - p0), 32'd0);
        wait_result("fill", 14, 16'd6);

        // Window 2..12,25: sum 102, avg 8.
        push(16'd25, 1'b0);
        wait_result("slide", 14, 16'd8);
        repeat (3) @(posedge clk);
        #1;
        check("hold", 32'(dout), 32'd8);

        // Replace the oldest (2) with 2: avg stays 8, mean output.
        push(16'd2, 1'b1);
        wait_result("mode1", 2, 16'd8);

        // Six 10s and six 20s: avg 15, tie at distance 5 resolves to 10.
        for (int i = 0; i < 12; i++) begin
            push((i % 2) != 0 ? 16'd20 : 16'd10, (i == 11) ? 1'b0 : 1'b1);
        end
        wait_result("tie", 14, 16'd10);

        // Full-scale samples: no sum overflow in either mode.
        for (int i = 0; i < 12; i++) push(16'hFFFF, 1'b1);
        wait_result("max_m1", 2, 16'hFFFF);
        push(16'hFFFF, 1'b0);
        wait_result("max_m0", 14, 16'hFFFF);

        // Continuous valid: one accept per 15 cycles, results match accepts.
        p0        = pulses;
        prev      = 0;
        gaps_bad  = 0;
        mode      = 1'b0;
        din_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            int n;
            n   = 0;
            din = DW'(i + 1);
            while (!din_ready && n < 100) begin
                @(posedge clk); #1;
                n++;
            end
            if (!din_ready) check("stream_timeout", 32'(din_ready), 32'd1);
            @(posedge clk); #1;
            if (i > 0 && (cyc - prev) != 15) gaps_bad++;
            prev = cyc;
        end
        din_valid = 1'b0;
        wait_result("stream_last", 14, 16'd6);
        check("stream_gaps", 32'(gaps_bad), 32'd0);
        check("stream_pulses", 32'(pulses - p0), 32'd12);

        // Reset during SCAN aborts the operation.
        push(16'd7, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("abort_ready", 32'(ready), 32'd0);
        check("abort_dout", 32'(dout), 32'd0);
        check("abort_dout_valid", 32'(dout_valid), 32'd0);
        p0    = pulses;
        reset = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("abort_no_dv", 32'(pulses - p0), 32'd0);

        for (int i = 0; i < 12; i++) push(16'd7, 1'b0);
        check("refill_ready", 32'(ready), 32'd1);
        wait_result("refill", 14, 16'd7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/avg_window.md
Name: avg_window

Overview:
- Parameterised sliding-window averager. Keeps the last DEPTH accepted samples in a circular buffer, maintains a running sum, and computes the floor mean.
- Depending on mode, outputs either the mean or the window sample closest to the mean.
- Sits in the sample datapath between an upstream valid/ready producer and a downstream consumer.
- Successor to the fixed 12×16 averager, adding:
  - configurable width and depth;
  - a real input handshake;
  - a multi-cycle sequential search;
  - an output-select mode.

Parameters:
DW, 16, sample/result width in bits
DEPTH, 12, window length in samples (2..64)
SW, DW+$clog2(DEPTH), running-sum width (derived; never overridden)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset; sampled on rising clk
din  input  DW  sample data
din_valid  input  1  din is valid this cycle
din_ready  output  1  block can accept a sample this cycle
mode  input  1  0 = output sample closest to mean, 1 = output mean itself
ready  output  1  window has been filled at least once since reset
dout  output  DW  result
dout_valid  output  1  single-cycle pulse, dout updated this cycle

Behaviour:
- Reset (reset==0 at a rising edge):
  - ready=0, dout=0, dout_valid=0, din_ready=0 during the reset cycle.
  - count=0, wr_ptr=0, sum=0; state=FILL.
  - Buffer contents are don't-care.
  - Reset mid-operation aborts any CALC/SCAN with no dout_valid.
- Accept: a sample is accepted on an edge with din_valid && din_ready. din_ready=1 only in FILL and WAIT.
- FILL (count<DEPTH):
  - On accept: buf[wr_ptr]=din, sum+=din, count++, wr_ptr++.
  - Nothing is output.
  - When count reaches DEPTH: ready=1 (sticky until reset), go to CALC.
- WAIT (window full, idle):
  - On accept: sum=sum-buf[wr_ptr]+din, buf[wr_ptr]=din (oldest entry replaced), wr_ptr advances; go to CALC.
- wr_ptr wraps DEPTH-1 -> 0. The oldest entry is always at wr_ptr.
- CALC (1 cycle):
  - avg = sum/DEPTH, unsigned floor, registered; avg always fits DW.
  - mode is sampled here and held for the whole operation.
  - mode=1: dout=avg, dout_valid=1 on the next edge, go to WAIT.
  - mode=0: go to SCAN with idx=0, best_dist = all-ones (DW bits).
- SCAN (exactly DEPTH cycles, one entry per cycle, idx 0..DEPTH-1 over buf[] storage order):
  - d = |buf[idx]-avg|, unsigned DW bits, no overflow.
  - Replace best when d<best_dist.
  - Tie (d==best_dist): replace only if buf[idx]<=avg. A below-or-equal-mean sample wins over an above-mean one; equal-valued samples give the same result.
  - After idx=DEPTH-1: dout=best, dout_valid=1 for one cycle, go to WAIT.
- Latency, counted from the accept edge k:
  - mode=1: dout_valid at edge k+2.
  - mode=0: dout_valid at edge k+DEPTH+2.
- din_ready=0 throughout CALC/SCAN. Upstream holds din/din_valid; no sample is lost or duplicated.
- dout holds its last value between pulses. dout_valid is never high in FILL.
- sum is never negative or overflowing: sum <= DEPTH*(2^DW-1) < 2^SW.
- The first CALC uses the complete window: the DEPTH-th sample is included in sum before CALC.

Test Plan:
- Defaults, mode=0, feed 1..12 back-to-back → ready rises on the 12th accept; sum 78, avg 6; dout=6, dout_valid one pulse 14 cycles after the 12th accept; din_ready low for those cycles.
- Continue with sample 25, mode=0 → window 2..12,25; sum 102, avg 8; dout=8. Repeat with mode=1 → dout=8 two cycles after accept.
- Window of six 10s and six 20s (interleaved), mode=0 → avg 15, tie at distance 5; dout=10.
- Twelve samples of 0xFFFF, mode=1 then mode=0 → no sum overflow; dout=0xFFFF in both modes.
- din_valid held high continuously after fill → exactly one accept per 15 cycles (mode=0); every input consumed once in order; a dout_valid count equal to the accept count.
- Assert reset (low) during SCAN → next edge: ready=0, dout=0, no dout_valid. Then refill with twelve 7s → dout=7.
